// File: rtl/alu_arbiter_if.sv
// alu_arbiter_if: bundles the two requester channels, the two response
// channels, the ALU drive/return lines and the busy flag of alu_arbiter.
//   req<n>_valid/ready/a/b/sel : operation request from requester n
//   rsp<n>_valid/ready/out/zero: captured ALU result returned to requester n
//   alu_a/alu_b/alu_sel        : operands and select driven to the ALU
//   alu_out/alu_zero           : combinational ALU result
//   busy                       : arbiter is not idle
// Modport slave is the arbiter; modport master is the requester/ALU side.
interface alu_arbiter_if #(
  parameter int WL = 32,
  parameter int SL = 5
);
  logic          req0_valid;
  logic          req0_ready;
  logic [WL-1:0] req0_a;
  logic [WL-1:0] req0_b;
  logic [SL-1:0] req0_sel;
  logic          req1_valid;
  logic          req1_ready;
  logic [WL-1:0] req1_a;
  logic [WL-1:0] req1_b;
  logic [SL-1:0] req1_sel;

  logic          rsp0_valid;
  logic          rsp0_ready;
  logic [WL-1:0] rsp0_out;
  logic          rsp0_zero;
  logic          rsp1_valid;
  logic          rsp1_ready;
  logic [WL-1:0] rsp1_out;
  logic          rsp1_zero;

  logic [WL-1:0] alu_a;
  logic [WL-1:0] alu_b;
  logic [SL-1:0] alu_sel;
  logic [WL-1:0] alu_out;
  logic          alu_zero;

  logic          busy;

  modport slave (
    input  req0_valid, req0_a, req0_b, req0_sel,
    input  req1_valid, req1_a, req1_b, req1_sel,
    input  rsp0_ready, rsp1_ready,
    input  alu_out, alu_zero,
    output req0_ready, req1_ready,
    output rsp0_valid, rsp0_out, rsp0_zero,
    output rsp1_valid, rsp1_out, rsp1_zero,
    output alu_a, alu_b, alu_sel,
    output busy
  );

  modport master (
    output req0_valid, req0_a, req0_b, req0_sel,
    output req1_valid, req1_a, req1_b, req1_sel,
    output rsp0_ready, rsp1_ready,
    output alu_out, alu_zero,
    input  req0_ready, req1_ready,
    input  rsp0_valid, rsp0_out, rsp0_zero,
    input  rsp1_valid, rsp1_out, rsp1_zero,
    input  alu_a, alu_b, alu_sel,
    input  busy
  );
endinterface

// File: rtl/alu_arbiter.sv
// alu_arbiter: shares one combinational ALU between two requesters.
// One operation at a time is granted round-robin, its operands are
// registered and driven to the ALU, and the ALU result is captured and
// held on the granted requester's response channel until accepted.
//   CLK : clock, all state updates on the rising edge
//   RST : synchronous active-high reset
//   bus : alu_arbiter_if slave modport (request, response, ALU, busy)
module alu_arbiter #(
  parameter int WL = 32,
  parameter int SL = 5
) (
  input logic         CLK,
  input logic         RST,
  alu_arbiter_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t        state, state_nxt;
  logic          gnt_id;     // owner of the in-flight operation
  logic          last_gnt;   // round-robin history
  logic [WL-1:0] op_a, op_b;
  logic [SL-1:0] op_sel;
  logic [WL-1:0] res_out;
  logic          res_zero;

  logic          grant;      // an operation is accepted this cycle
  logic          win;        // id of the accepted requester
  logic          rsp_take;   // granted requester takes the result

  assign rsp_take = gnt_id ? bus.rsp1_ready : bus.rsp0_ready;

  // NOTE: every variable of a combinational block gets a default before the
  // case so no path leaves it unassigned and no latch is inferred.
  always_comb begin
    state_nxt = state;
    grant     = 1'b0;
    win       = 1'b0;
    case (state)
      IDLE: begin
        // With both valid the one that did not win last time goes first.
        if (bus.req0_valid && bus.req1_valid) win = ~last_gnt;
        else                                  win = bus.req1_valid;
        if (bus.req0_valid || bus.req1_valid) begin
          // Ready is withheld while reset is applied.
          grant     = ~RST;
          state_nxt = EXEC;
        end
      end
      EXEC:    state_nxt = RESP;
      RESP:    if (rsp_take) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // NOTE: state registers use non-blocking assignments so every register
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge CLK) begin
    if (RST) begin
      // NOTE: operand and result registers are reset too, so the ALU inputs
      // and response data are defined from the first cycle after reset.
      state    <= IDLE;
      gnt_id   <= 1'b0;
      last_gnt <= 1'b1;
      op_a     <= '0;
      op_b     <= '0;
      op_sel   <= '0;
      res_out  <= '0;
      res_zero <= 1'b0;
    end else begin
      state <= state_nxt;
      if (grant) begin
        op_a     <= win ? bus.req1_a   : bus.req0_a;
        op_b     <= win ? bus.req1_b   : bus.req0_b;
        op_sel   <= win ? bus.req1_sel : bus.req0_sel;
        gnt_id   <= win;
        last_gnt <= win;
      end
      // The ALU result is only meaningful while our operands drive it.
      if (state == EXEC) begin
        res_out  <= bus.alu_out;
        res_zero <= bus.alu_zero;
      end
    end
  end

  assign bus.req0_ready = grant & ~win;
  assign bus.req1_ready = grant &  win;

  assign bus.alu_a   = op_a;
  assign bus.alu_b   = op_b;
  assign bus.alu_sel = op_sel;

  assign bus.rsp0_valid = (state == RESP) & ~gnt_id;
  assign bus.rsp1_valid = (state == RESP) &  gnt_id;
  assign bus.rsp0_out   = res_out;
  assign bus.rsp1_out   = res_out;
  assign bus.rsp0_zero  = res_zero;
  assign bus.rsp1_zero  = res_zero;

  assign bus.busy = (state != IDLE);

endmodule

// File: tb/tb_alu_arbiter.sv
// tb_alu_arbiter: directed bench for alu_arbiter with an ALU stub
// (sel 0 = add, sel 1 = subtract) and a scoreboard that records the expected
// result at each accepted request and compares it at each taken response.
module tb_alu_arbiter;
  localparam int WL = 32;
  localparam int SL = 5;

  typedef struct packed {
    logic          port;
    logic [WL-1:0] out;
    logic          zero;
  } exp_t;

  logic CLK = 1'b0;
  logic RST;

  alu_arbiter_if #(.WL(WL), .SL(SL)) bus ();

  alu_arbiter #(.WL(WL), .SL(SL)) dut (
    .CLK (CLK),
    .RST (RST),
    .bus (bus)
  );

  always #5 CLK = ~CLK;

  // ALU stub
  assign bus.alu_out  = (bus.alu_sel == 5'd0) ? bus.alu_a + bus.alu_b :
                        (bus.alu_sel == 5'd1) ? bus.alu_a - bus.alu_b : '0;
  assign bus.alu_zero = (bus.alu_out == '0);

  int   n_total = 0;
  int   n_pass  = 0;
  int   n_fail  = 0;
  int   n_rsp   = 0;
  int   exp_rsp = 0;
  exp_t sb[$];

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic exp_t model(input logic port, input logic [WL-1:0] a,
                                 input logic [WL-1:0] b, input logic [SL-1:0] sel);
    exp_t e;
    e.port = port;
    if (sel == 5'd0)      e.out = a + b;
    else if (sel == 5'd1) e.out = a - b;
    else                  e.out = '0;
    e.zero = (e.out == '0);
    return e;
  endfunction

  task automatic sb_pop(input logic port, input logic [WL-1:0] out, input logic zero);
    exp_t e;
    if (sb.size() == 0) begin
      check("sb_underflow", 64'(sb.size()), 64'd1);
    end else begin
      e = sb.pop_front();
      check("sb_port", {63'd0, port}, {63'd0, e.port});
      check("sb_out",  64'(out),      64'(e.out));
      check("sb_zero", {63'd0, zero}, {63'd0, e.zero});
      n_rsp++;
    end
  endtask

  // Scoreboard monitor, sampled mid-cycle.
  always @(negedge CLK) begin
    if (bus.req0_valid && bus.req0_ready)
      sb.push_back(model(1'b0, bus.req0_a, bus.req0_b, bus.req0_sel));
    if (bus.req1_valid && bus.req1_ready)
      sb.push_back(model(1'b1, bus.req1_a, bus.req1_b, bus.req1_sel));
    if (!RST && bus.rsp0_valid && bus.rsp0_ready)
      sb_pop(1'b0, bus.rsp0_out, bus.rsp0_zero);
    if (!RST && bus.rsp1_valid && bus.rsp1_ready)
      sb_pop(1'b1, bus.rsp1_out, bus.rsp1_zero);
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick;
    @(posedge CLK);
    #1;
  endtask

  initial begin
    bit w;
    RST            = 1'b1;
    bus.req0_valid = 1'b1;
    bus.req0_a     = 32'd5;
    bus.req0_b     = 32'd3;
    bus.req0_sel   = 5'd0;
    bus.req1_valid = 1'b0;
    bus.req1_a     = '0;
    bus.req1_b     = '0;
    bus.req1_sel   = '0;
    bus.rsp0_ready = 1'b1;
    bus.rsp1_ready = 1'b1;

    // Reset state; requester 0 valid but must not be accepted during reset.
    tick; tick; #1;
    check("rst_busy",       {63'd0, bus.busy},       64'd0);
    check("rst_rsp0_valid", {63'd0, bus.rsp0_valid}, 64'd0);
    check("rst_rsp1_valid", {63'd0, bus.rsp1_valid}, 64'd0);
    check("rst_req0_ready", {63'd0, bus.req0_ready}, 64'd0);
    check("rst_alu_a",      64'(bus.alu_a),          64'd0);
    check("rst_rsp0_out",   64'(bus.rsp0_out),       64'd0);

    // Single request: 5 + 3.
    RST = 1'b0; #1;
    check("single_req0_ready", {63'd0, bus.req0_ready}, 64'd1);
    check("single_req1_ready", {63'd0, bus.req1_ready}, 64'd0);
    exp_rsp++;
    tick; bus.req0_valid = 1'b0; #1;
    check("single_exec_busy",  {63'd0, bus.busy},       64'd1);
    check("single_exec_alu_a", 64'(bus.alu_a),          64'd5);
    check("single_exec_rsp0",  {63'd0, bus.rsp0_valid}, 64'd0);
    tick; #1;
    check("single_rsp0_valid", {63'd0, bus.rsp0_valid}, 64'd1);
    check("single_rsp0_out",   64'(bus.rsp0_out),       64'd8);
    check("single_rsp0_zero",  {63'd0, bus.rsp0_zero},  64'd0);
    check("single_rsp1_valid", {63'd0, bus.rsp1_valid}, 64'd0);
    tick; #1;
    check("single_done_busy",  {63'd0, bus.busy},       64'd0);

    // Contention from a fresh reset: grants 0,1,0,1 every 3 cycles.
    RST = 1'b1;
    tick;
    RST            = 1'b0;
    bus.req0_valid = 1'b1;
    bus.req0_a     = 32'd7;
    bus.req0_b     = 32'd7;
    bus.req0_sel   = 5'd1;
    bus.req1_valid = 1'b1;
    bus.req1_a     = 32'hFFFF_FFFE;
    bus.req1_b     = 32'd1;
    bus.req1_sel   = 5'd0;
    #1;
    for (int i = 0; i < 4; i++) begin
      w = (i % 2) == 1;
      check("rr_req0_ready", {63'd0, bus.req0_ready}, {63'd0, !w});
      check("rr_req1_ready", {63'd0, bus.req1_ready}, {63'd0, w});
      exp_rsp++;
      tick; #1;
      check("rr_exec_ready", {62'd0, bus.req1_ready, bus.req0_ready}, 64'd0);
      tick; #1;
      check("rr_rsp0_valid", {63'd0, bus.rsp0_valid}, {63'd0, !w});
      check("rr_rsp1_valid", {63'd0, bus.rsp1_valid}, {63'd0, w});
      check("rr_out",  64'(bus.rsp0_out), w ? 64'hFFFF_FFFF : 64'd0);
      check("rr_zero", {63'd0, bus.rsp0_zero}, {63'd0, !w});
      tick; #1;
    end

    // Back-pressure on requester 1.
    bus.req0_valid = 1'b0;
    bus.rsp1_ready = 1'b0;
    #1;
    check("bp_req1_ready", {63'd0, bus.req1_ready}, 64'd1);
    exp_rsp++;
    tick; bus.req0_valid = 1'b1; #1;
    tick; #1;
    for (int k = 0; k < 5; k++) begin
      check("bp_rsp1_valid", {63'd0, bus.rsp1_valid}, 64'd1);
      check("bp_rsp1_out",   64'(bus.rsp1_out),       64'hFFFF_FFFF);
      check("bp_rsp0_valid", {63'd0, bus.rsp0_valid}, 64'd0);
      check("bp_req_ready",  {62'd0, bus.req1_ready, bus.req0_ready}, 64'd0);
      check("bp_busy",       {63'd0, bus.busy},       64'd1);
      tick; #1;
    end
    bus.rsp1_ready = 1'b1; #1;
    check("bp_release_valid", {63'd0, bus.rsp1_valid}, 64'd1);
    tick; #1;
    check("bp_next_req0_ready", {63'd0, bus.req0_ready}, 64'd1);
    check("bp_next_req1_ready", {63'd0, bus.req1_ready}, 64'd0);

    // Reset in EXEC discards the operation; next contention goes to 0.
    tick; #1;
    check("rstx_exec_busy", {63'd0, bus.busy}, 64'd1);
    RST = 1'b1;
    sb.delete();
    tick; #1;
    check("rstx_busy",       {63'd0, bus.busy},       64'd0);
    check("rstx_rsp0_valid", {63'd0, bus.rsp0_valid}, 64'd0);
    check("rstx_rsp1_valid", {63'd0, bus.rsp1_valid}, 64'd0);
    check("rstx_req0_ready", {63'd0, bus.req0_ready}, 64'd0);
    RST = 1'b0; #1;
    check("rstx_grant0", {63'd0, bus.req0_ready}, 64'd1);
    check("rstx_grant1", {63'd0, bus.req1_ready}, 64'd0);
    exp_rsp++;
    tick; bus.req1_valid = 1'b0; bus.req0_valid = 1'b0; #1;
    check("rstx_exec_rsp", {62'd0, bus.rsp1_valid, bus.rsp0_valid}, 64'd0);
    tick; #1;
    check("rstx_rsp0_valid2", {63'd0, bus.rsp0_valid}, 64'd1);
    check("rstx_rsp0_zero",   {63'd0, bus.rsp0_zero},  64'd1);
    tick; #1;

    // Operand stability after acceptance.
    bus.req0_valid = 1'b1;
    bus.req0_a     = 32'h10;
    bus.req0_b     = 32'h1;
    bus.req0_sel   = 5'd0;
    #1;
    check("stab_req0_ready", {63'd0, bus.req0_ready}, 64'd1);
    exp_rsp++;
    tick; bus.req0_a = 32'hFF; bus.req0_valid = 1'b0; #1;
    check("stab_exec_alu_a", 64'(bus.alu_a), 64'h10);
    tick; #1;
    check("stab_rsp0_out", 64'(bus.rsp0_out), 64'h11);
    check("stab_alu_a",    64'(bus.alu_a),    64'h10);
    tick; #1;

    // Max positive plus one wraps bit-exact.
    bus.req0_valid = 1'b1;
    bus.req0_a     = 32'h7FFF_FFFF;
    bus.req0_b     = 32'h1;
    bus.req0_sel   = 5'd0;
    #1;
    check("max_req0_ready", {63'd0, bus.req0_ready}, 64'd1);
    exp_rsp++;
    tick; bus.req0_valid = 1'b0; #1;
    tick; #1;
    check("max_rsp0_valid", {63'd0, bus.rsp0_valid}, 64'd1);
    check("max_rsp0_out",   64'(bus.rsp0_out),       64'h8000_0000);
    check("max_rsp0_zero",  {63'd0, bus.rsp0_zero},  64'd0);
    tick; #1;

    check("sb_left",  64'(sb.size()), 64'd0);
    check("rsp_seen", 64'(n_rsp),     64'(exp_rsp));

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
